// File: rtl/i2c_reg_seq.sv
// Register-access sequencer for the byte-level i2c master: turns one host read/write
// request into the master's en/data handshake and aborts transfers that stall.
module i2c_reg_seq #(
    parameter int TO_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic       rsp_valid,
    output logic       rsp_err,
    output logic [7:0] rsp_rdata,
    output logic [1:0] i2c_en,
    output logic [7:0] i2c_data,
    input  logic [2:0] i2c_st,
    input  logic [7:0] i2c_rdata
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ADDR_W = 3'd1;
    localparam logic [2:0] REG    = 3'd2;
    localparam logic [2:0] WDATA  = 3'd3;
    localparam logic [2:0] STOP1  = 3'd4;
    localparam logic [2:0] ADDR_R = 3'd5;
    localparam logic [2:0] RDATA  = 3'd6;
    localparam logic [2:0] FINISH = 3'd7;

    localparam logic [1:0] EN_STOP = 2'd0;
    localparam logic [1:0] EN_RD   = 2'd1;
    localparam logic [1:0] EN_WR   = 2'd2;

    localparam logic [2:0] ST_ACK  = 3'd2;
    localparam logic [2:0] ST_STOP = 3'd7;

    localparam int CW = $clog2(TO_CYCLES);

    logic [2:0]    state;
    logic [2:0]    st_q;
    logic [CW-1:0] wd_cnt;
    logic          rd_q;
    logic [6:0]    dev_q;
    logic [7:0]    reg_q;
    logic [7:0]    wdata_q;

    logic accept;
    logic ack_e;
    logic stop_e;
    logic st_chg;
    logic wd_expire;

    // A new request is only taken once the master itself is parked in STOP.
    assign req_ready = (state == IDLE) && (i2c_st == ST_STOP);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    assign ack_e     = (i2c_st == ST_ACK)  && (st_q != ST_ACK);
    assign stop_e    = (i2c_st == ST_STOP) && (st_q != ST_STOP);
    assign st_chg    = (i2c_st != st_q);
    assign wd_expire = busy && (wd_cnt == CW'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_STOP;
            wd_cnt <= '0;
        end else begin
            st_q <= i2c_st;
            if (accept || wd_expire || st_chg) begin
                wd_cnt <= '0;
            end else if (busy) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
        end
    end

    // The watchdog abort takes priority over any event seen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'h00;
            i2c_en    <= EN_STOP;
            i2c_data  <= 8'h00;
            rd_q      <= 1'b0;
            dev_q     <= 7'h00;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            if (wd_expire) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                i2c_en    <= EN_STOP;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            rd_q     <= req_rd;
                            dev_q    <= req_dev;
                            reg_q    <= req_reg;
                            wdata_q  <= req_wdata;
                            i2c_data <= {req_dev, 1'b0};
                            i2c_en   <= EN_WR;
                            state    <= ADDR_W;
                        end
                    end
                    ADDR_W: begin
                        if (ack_e) begin
                            i2c_data <= reg_q;
                            i2c_en   <= EN_WR;
                            state    <= REG;
                        end
                    end
                    REG: begin
                        if (ack_e && !rd_q) begin
                            i2c_data <= wdata_q;
                            i2c_en   <= EN_WR;
                            state    <= WDATA;
                        end else if (ack_e) begin
                            i2c_en <= EN_STOP;
                            state  <= STOP1;
                        end
                    end
                    WDATA: begin
                        if (ack_e) begin
                            i2c_en <= EN_STOP;
                            state  <= FINISH;
                        end
                    end
                    // Repeated-start is built as STOP followed by a fresh read transfer.
                    STOP1: begin
                        if (stop_e) begin
                            i2c_data <= {dev_q, 1'b1};
                            i2c_en   <= EN_RD;
                            state    <= ADDR_R;
                        end
                    end
                    ADDR_R: begin
                        if (ack_e) begin
                            i2c_en <= EN_STOP;
                            state  <= RDATA;
                        end
                    end
                    RDATA: begin
                        if (stop_e) begin
                            rsp_rdata <= i2c_rdata;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            i2c_en    <= EN_STOP;
                            state     <= IDLE;
                        end
                    end
                    FINISH: begin
                        if (stop_e) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            i2c_en    <= EN_STOP;
                            state     <= IDLE;
                        end
                    end
                    default: begin
                        i2c_en <= EN_STOP;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: a transaction-level i2c master + slave register file drives i2c_st,
// and every response is compared against a shadow register map and expected bus bytes.
module tb_i2c_reg_seq;

    localparam int TO = 64;

    localparam logic [1:0] EN_STOP = 2'd0;
    localparam logic [1:0] EN_RD   = 2'd1;
    localparam logic [1:0] EN_WR   = 2'd2;

    localparam logic [2:0] S_START = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_ACK   = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_ACKRD = 3'd4;
    localparam logic [2:0] S_Z     = 3'd5;
    localparam logic [2:0] S_SCLK  = 3'd6;
    localparam logic [2:0] S_STOP  = 3'd7;

    localparam logic [6:0] SLV = 7'h50;

    typedef struct {
        logic       rd;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic       exp_err;
        logic [7:0] exp_rdata;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_rd;
    logic [6:0] req_dev;
    logic [7:0] req_reg;
    logic [7:0] req_wdata;
    logic       busy;
    logic       rsp_valid;
    logic       rsp_err;
    logic [7:0] rsp_rdata;
    logic [1:0] i2c_en;
    logic [7:0] i2c_data;
    logic [2:0] i2c_st;
    logic [7:0] i2c_rdata;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_chg = 0;
    int         ack_rd_cnt = 0;
    logic [2:0] prev_st = S_STOP;
    logic [7:0] slv_regs [256];
    logic [7:0] slv_ptr;
    logic [7:0] ref_regs [256];
    logic [7:0] bus_log [$];
    logic [7:0] last_rdata;
    bit         abort_req;
    bit         rd_phase;

    i2c_reg_seq #(.TO_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_dev   (req_dev),
        .req_reg   (req_reg),
        .req_wdata (req_wdata),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .i2c_en    (i2c_en),
        .i2c_data  (i2c_data),
        .i2c_st    (i2c_st),
        .i2c_rdata (i2c_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and the edge at which the sequencer last saw i2c_st move.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (i2c_st !== prev_st) last_chg = cyc;
        prev_st = i2c_st;
    end

    task automatic m_hold(input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            if (abort_req) return;
            @(negedge clk);
            if (abort_req) return;
            i2c_st = s;
        end
    endtask

    // One bus transfer as the master performs it; a NACKed address freezes it in WR.
    task automatic master_txn();
        logic       rd_mode;
        logic [7:0] sh;
        int         idx;
        bit         more;
        rd_mode  = (i2c_en == EN_RD);
        rd_phase = rd_mode;
        sh       = i2c_data;
        idx      = 0;
        more     = 1'b1;
        m_hold(S_START, 2);
        while (more && !abort_req) begin
            m_hold(S_WR, 8);
            if (abort_req) return;
            bus_log.push_back(sh);
            if (idx == 0 && sh[7:1] != SLV) begin
                while (!abort_req) @(negedge clk);
                return;
            end
            if (!rd_mode && idx == 1) begin
                slv_ptr = sh;
            end else if (!rd_mode && idx >= 2) begin
                slv_regs[slv_ptr] = sh;
                slv_ptr = slv_ptr + 8'd1;
            end
            idx++;
            m_hold(S_ACK, 2);
            if (abort_req) return;
            if (rd_mode) begin
                i2c_rdata = slv_regs[slv_ptr];
                m_hold(S_RD, 8);
                if (i2c_en != EN_STOP) begin
                    ack_rd_cnt++;
                    m_hold(S_ACKRD, 2);
                end
                more = 1'b0;
            end else if (i2c_en == EN_WR) begin
                sh = i2c_data;
            end else begin
                more = 1'b0;
            end
        end
        if (abort_req) return;
        m_hold(S_Z, 1);
        m_hold(S_SCLK, 1);
        m_hold(S_STOP, 1);
    endtask

    initial begin
        i2c_st    = S_STOP;
        i2c_rdata = 8'h00;
        slv_ptr   = 8'h00;
        rd_phase  = 1'b0;
        for (int i = 0; i < 256; i++) slv_regs[i] = 8'h00;
        slv_regs[8'h20] = 8'h3C;
        forever begin
            @(negedge clk);
            if (abort_req) begin
                i2c_st = S_STOP;
            end else if (rst_n && i2c_en != EN_STOP) begin
                master_txn();
                rd_phase = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                                 input logic [7:0] wd, input bit hold);
        int n;
        n = 0;
        while (!req_ready && n < 2000) begin
            tick();
            n++;
        end
        checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
        req_rd    = rd;
        req_dev   = dev;
        req_reg   = rg;
        req_wdata = wd;
        req_valid = 1'b1;
        tick();
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("rsp_arrives", 32'(got), 32'd1);
    endtask

    task automatic wait_stop();
        int n;
        n = 0;
        while (i2c_st != S_STOP && n < 100) begin
            tick();
            n++;
        end
        checkOutput("master_parked", 32'(i2c_st), 32'(S_STOP));
    endtask

    // Reference: a write lands in the register map; a read returns it; bus bytes follow the request.
    task automatic check_txn(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [7:0] wd, input int base, input int acb);
        logic [7:0] exp_b [3];
        exp_b[0] = {dev, 1'b0};
        exp_b[1] = rg;
        exp_b[2] = rd ? {dev, 1'b1} : wd;
        checkOutput("bus_len", 32'(bus_log.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (base + i < bus_log.size())
                checkOutput("bus_byte", 32'(bus_log[base + i]), 32'(exp_b[i]));
        end
        checkOutput("rsp_err", 32'(rsp_err), 32'd0);
        if (rd) begin
            checkOutput("rd_data", 32'(rsp_rdata), 32'(ref_regs[rg]));
            checkOutput("no_ack_rd", 32'(ack_rd_cnt - acb), 32'd0);
            last_rdata = ref_regs[rg];
        end else begin
            ref_regs[rg] = wd;
            checkOutput("slave_reg", 32'(slv_regs[rg]), 32'(wd));
            checkOutput("rdata_hold", 32'(rsp_rdata), 32'(last_rdata));
        end
    endtask

    initial begin
        vec_t       vecs [4];
        int         base;
        int         acb;
        int         e;
        int         hits;
        bit         got;
        bit         found;
        logic       rd;
        logic [7:0] rg;
        logic [7:0] wd;

        vecs[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 7'h50, 8'h20, 8'h00, 1'b0, 8'h3C};
        vecs[2] = '{1'b1, 7'h50, 8'h10, 8'h00, 1'b0, 8'hA5};
        vecs[3] = '{1'b0, 7'h51, 8'h05, 8'h77, 1'b1, 8'h00};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_rd     = 1'b0;
        req_dev    = 7'h00;
        req_reg    = 8'h00;
        req_wdata  = 8'h00;
        abort_req  = 1'b0;
        last_rdata = 8'h00;
        for (int i = 0; i < 256; i++) ref_regs[i] = 8'h00;
        ref_regs[8'h20] = 8'h3C;

        repeat (3) tick();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        checkOutput("rst_i2c_en", 32'(i2c_en), 32'(EN_STOP));
        checkOutput("rst_i2c_data", 32'(i2c_data), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("rst_ready", 32'(req_ready), 32'd1);

        // Directed table: write, preloaded read, read-back, NACKed address.
        for (int i = 0; i < 4; i++) begin
            base = bus_log.size();
            acb  = ack_rd_cnt;
            applyStimulus(vecs[i].rd, vecs[i].dev, vecs[i].rg, vecs[i].wd, 1'b0);
            checkOutput("tbl_busy", 32'(busy), 32'd1);
            wait_rsp(got);
            checkOutput("tbl_err", 32'(rsp_err), 32'(vecs[i].exp_err));
            if (vecs[i].exp_err) begin
                checkOutput("wd_delay", 32'(cyc - last_chg), 32'(TO));
                checkOutput("wd_busy", 32'(busy), 32'd0);
                checkOutput("wd_i2c_en", 32'(i2c_en), 32'(EN_STOP));
                checkOutput("wd_rdata_hold", 32'(rsp_rdata), 32'(last_rdata));
                checkOutput("wd_ready_low", 32'(req_ready), 32'd0);
                tick();
                checkOutput("wd_pulse", 32'(rsp_valid), 32'd0);
                abort_req = 1'b1;
                wait_stop();
                abort_req = 1'b0;
                checkOutput("wd_recover_ready", 32'(req_ready), 32'd1);
            end else begin
                if (vecs[i].rd) checkOutput("tbl_rdata", 32'(rsp_rdata), 32'(vecs[i].exp_rdata));
                check_txn(vecs[i].rd, vecs[i].dev, vecs[i].rg, vecs[i].wd, base, acb);
                tick();
                checkOutput("rsp_pulse", 32'(rsp_valid), 32'd0);
            end
        end

        // Request held with changed fields while busy must be ignored.
        base = bus_log.size();
        acb  = ack_rd_cnt;
        applyStimulus(1'b0, SLV, 8'h30, 8'h5A, 1'b1);
        req_rd    = 1'b1;
        req_dev   = 7'h22;
        req_reg   = 8'h31;
        req_wdata = 8'hFF;
        hits = 0;
        got  = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (req_ready) hits++;
            tick();
        end
        req_valid = 1'b0;
        checkOutput("hold_rsp", 32'(got), 32'd1);
        checkOutput("hold_ready_low", 32'(hits), 32'd0);
        checkOutput("hold_ready_at_rsp", 32'(req_ready), 32'd1);
        check_txn(1'b0, SLV, 8'h30, 8'h5A, base, acb);
        checkOutput("hold_ignored", 32'(slv_regs[8'h31]), 32'(ref_regs[8'h31]));
        tick();
        checkOutput("hold_no_reaccept", 32'(busy), 32'd0);

        // Back-to-back: read issued in the rsp_valid cycle is accepted on the next edge.
        base = bus_log.size();
        acb  = ack_rd_cnt;
        applyStimulus(1'b0, SLV, 8'h01, 8'h11, 1'b0);
        wait_rsp(got);
        check_txn(1'b0, SLV, 8'h01, 8'h11, base, acb);
        e    = cyc;
        base = bus_log.size();
        applyStimulus(1'b1, SLV, 8'h01, 8'h00, 1'b0);
        checkOutput("b2b_accept_cycle", 32'(cyc), 32'(e + 1));
        checkOutput("b2b_busy", 32'(busy), 32'd1);
        checkOutput("b2b_pulse", 32'(rsp_valid), 32'd0);
        wait_rsp(got);
        checkOutput("b2b_rdata", 32'(rsp_rdata), 32'h11);
        check_txn(1'b1, SLV, 8'h01, 8'h00, base, acb);
        tick();

        // Asynchronous reset while the read address byte is on the bus.
        applyStimulus(1'b1, SLV, 8'h20, 8'h00, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (rd_phase && i2c_st == S_WR) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("reach_addr_r", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_i2c_en", 32'(i2c_en), 32'(EN_STOP));
        checkOutput("arst_rdata", 32'(rsp_rdata), 32'd0);
        abort_req = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        hits = 0;
        for (int n = 0; n < 20; n++) begin
            if (rsp_valid) hits++;
            tick();
        end
        checkOutput("arst_no_rsp", 32'(hits), 32'd0);
        wait_stop();
        abort_req  = 1'b0;
        last_rdata = 8'h00;
        base = bus_log.size();
        acb  = ack_rd_cnt;
        applyStimulus(1'b0, SLV, 8'h40, 8'h9C, 1'b0);
        wait_rsp(got);
        if (got) check_txn(1'b0, SLV, 8'h40, 8'h9C, base, acb);

        // Random traffic over a small register window so reads hit earlier writes.
        for (int i = 0; i < 24; i++) begin
            rd   = 1'($urandom_range(0, 1));
            rg   = 8'($urandom_range(0, 15));
            wd   = 8'($urandom);
            base = bus_log.size();
            acb  = ack_rd_cnt;
            applyStimulus(rd, SLV, rg, wd, 1'b0);
            wait_rsp(got);
            if (got) check_txn(rd, SLV, rg, wd, base, acb);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
